// File: rtl/iob_axis2axi_wr_pkg.sv
// Shared definitions for the AXI-Stream to AXI4 write bridge: FSM encoding,
// fixed AXI attribute values and the 4 KiB boundary constant.
package iob_axis2axi_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_FILL = 3'd2,
    ST_ADDR = 3'd3,
    ST_DATA = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  // Fixed AW attributes: 4-byte beats, incrementing bursts, modifiable cache,
  // non-secure unprivileged data access.
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'd2;
  localparam logic [2:0] AXI_PROT_NS    = 3'd2;

  // AXI bursts may not cross this byte boundary.
  localparam logic [12:0] BOUNDARY_4K = 13'h1000;

endpackage

// File: rtl/iob_axis2axi_wr_buf.sv
// First-word-fall-through synchronous FIFO of 2**ADDR_W words with a level
// output. The head word is visible on data_o whenever empty_o is low.
module iob_axis2axi_wr_buf
  import iob_axis2axi_wr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W:0]   level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (level_q == (ADDR_W + 1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Next pointer and level values; a simultaneous push and pop keeps the level.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers, cleared by reset and frozen when cke_i is low.
  always_ff @(posedge clk_i or posedge arst_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (cke_i) begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Word storage write port.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array has no reset; the pointers alone define valid contents.
    if (cke_i && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/iob_axis2axi_wr.sv
// AXI-Stream to AXI4 write bridge. A (start address, word count) command is
// split into INCR bursts of at most 2**BURST_W beats that never cross a 4 KiB
// boundary; stream words are buffered so W-channel stalls do not stall the
// producer. One burst is outstanding at a time and AW always precedes W.
// Optional: define IOB_AXIS2AXI_WR_BRESP_CHECK_EN to add a sticky error_o
// flag raised by a non-OKAY write response or a non-zero BID.
module iob_axis2axi_wr
  import iob_axis2axi_wr_pkg::*;
#(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int BURST_W    = 4
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    arst_i,
  // Command
  input  logic [AXI_ADDR_W-1:0]   config_in_addr_i,
  input  logic [AXI_ADDR_W-1:0]   config_in_length_i,
  input  logic                    config_in_valid_i,
  output logic                    config_in_ready_o,
  // Stream input
  input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
  input  logic                    axis_in_valid_i,
  output logic                    axis_in_ready_o,
`ifdef IOB_AXIS2AXI_WR_BRESP_CHECK_EN
  output logic                    error_o,
`endif
  // AXI write address
  output logic [AXI_ID_W-1:0]     axi_awid_o,
  output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]    axi_awlen_o,
  output logic [2:0]              axi_awsize_o,
  output logic [1:0]              axi_awburst_o,
  output logic [1:0]              axi_awlock_o,
  output logic [3:0]              axi_awcache_o,
  output logic [2:0]              axi_awprot_o,
  output logic [3:0]              axi_awqos_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  // AXI write data
  output logic [AXI_DATA_W-1:0]   axi_wdata_o,
  output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
  output logic                    axi_wlast_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  // AXI write response
  input  logic [AXI_ID_W-1:0]     axi_bid_i,
  input  logic [1:0]              axi_bresp_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o
);

  localparam int BURST_SIZE = 2 ** BURST_W;
  localparam int BCNT_W     = BURST_W + 1;
  localparam int CMP_W      = (AXI_ADDR_W > 12) ? AXI_ADDR_W : 12;

  state_e                state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [AXI_ADDR_W-1:0] remaining_q, remaining_d;
  logic [AXI_ADDR_W-1:0] accept_cnt_q, accept_cnt_d;
  logic [BCNT_W-1:0]     burst_q, burst_d;
  logic [BCNT_W-1:0]     beat_q, beat_d;
  logic [AXI_LEN_W-1:0]  awlen_q, awlen_d;

  logic [11:0]           words_to_4k;
  logic [CMP_W-1:0]      burst_min;
  logic [BCNT_W-1:0]     burst_calc;

  logic                  cfg_fire;
  logic                  axis_push;
  logic                  w_pop;
  logic                  last_beat;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [BURST_W+1:0]    fifo_level;
  logic [AXI_DATA_W-1:0] fifo_head;

  assign cfg_fire  = config_in_valid_i && config_in_ready_o;
  assign axis_push = axis_in_valid_i && axis_in_ready_o;
  assign w_pop     = axi_wvalid_o && axi_wready_i;
  assign last_beat = (beat_q == burst_q - BCNT_W'(1));

  // Stream acceptance is independent of the FSM: it only needs words still
  // owed by the current command and room in the buffer.
  assign axis_in_ready_o = (accept_cnt_q != '0) && !fifo_full;

  iob_axis2axi_wr_buf #(
    .DATA_W (AXI_DATA_W),
    .ADDR_W (BURST_W + 1)
  ) u_buf (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .arst_i  (arst_i),
    .push_i  (axis_push),
    .data_i  (axis_in_data_i),
    .pop_i   (w_pop),
    .data_o  (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Words left before the next 4 KiB boundary; only meaningful when the
  // address space is large enough to contain such a boundary.
  if (AXI_ADDR_W >= 13) begin : g_split_4k
    assign words_to_4k = {1'b0, BOUNDARY_4K[12:2] - {1'b0, addr_q[11:2]}};
  end else begin : g_no_split_4k
    assign words_to_4k = '1;
  end

  // Size of the next burst: smallest of words left, max burst and 4 KiB room.
  always_comb begin
    burst_min = CMP_W'(remaining_q);
    if (CMP_W'(BURST_SIZE) < burst_min)  burst_min = CMP_W'(BURST_SIZE);
    if (CMP_W'(words_to_4k) < burst_min) burst_min = CMP_W'(words_to_4k);
    burst_calc = BCNT_W'(burst_min);
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)     state_q <= ST_IDLE;
    else if (cke_i) state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (cfg_fire && (config_in_length_i != '0)) state_d = ST_CALC;
      ST_CALC: state_d = ST_FILL;
      ST_FILL: if (fifo_level >= {1'b0, burst_q}) state_d = ST_ADDR;
      ST_ADDR: if (axi_awready_i) state_d = ST_DATA;
      ST_DATA: if (w_pop && last_beat) state_d = ST_RESP;
      ST_RESP: if (axi_bvalid_i) state_d = (remaining_q != '0) ? ST_CALC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake signals decoded from the current state.
  always_comb begin
    config_in_ready_o = 1'b0;
    axi_awvalid_o     = 1'b0;
    axi_wvalid_o      = 1'b0;
    axi_bready_o      = 1'b0;
    unique case (state_q)
      ST_IDLE: config_in_ready_o = 1'b1;
      ST_ADDR: axi_awvalid_o     = 1'b1;
      ST_DATA: axi_wvalid_o      = !fifo_empty;
      ST_RESP: axi_bready_o      = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: command latch, burst sizing, beat counting and
  // address advance after each completed burst.
  always_comb begin
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    accept_cnt_d = accept_cnt_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    awlen_d      = awlen_q;

    if (cfg_fire) begin
      addr_d       = config_in_addr_i & ~AXI_ADDR_W'(3);
      remaining_d  = config_in_length_i;
      accept_cnt_d = config_in_length_i;
    end else if (axis_push) begin
      accept_cnt_d = accept_cnt_q - AXI_ADDR_W'(1);
    end

    if (state_q == ST_CALC) begin
      burst_d     = burst_calc;
      awlen_d     = AXI_LEN_W'(burst_calc - BCNT_W'(1));
      remaining_d = remaining_q - AXI_ADDR_W'(burst_calc);
      beat_d      = '0;
    end

    if (w_pop) begin
      if (last_beat) begin
        beat_d = '0;
        addr_d = addr_q + (AXI_ADDR_W'(burst_q) << 2);
      end else begin
        beat_d = beat_q + BCNT_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      accept_cnt_q <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      awlen_q      <= '0;
    end else if (cke_i) begin
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      accept_cnt_q <= accept_cnt_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      awlen_q      <= awlen_d;
    end
  end

  // AW payload: address and length are registered, the rest is fixed.
  assign axi_awid_o    = '0;
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = awlen_q;
  assign axi_awsize_o  = AXI_SIZE_4B;
  assign axi_awburst_o = AXI_BURST_INCR;
  assign axi_awlock_o  = '0;
  assign axi_awcache_o = AXI_CACHE_MOD;
  assign axi_awprot_o  = AXI_PROT_NS;
  assign axi_awqos_o   = '0;

  // W payload: buffer head, masked while not valid so idle outputs read 0.
  assign axi_wdata_o = axi_wvalid_o ? fifo_head : '0;
  assign axi_wstrb_o = '1;
  assign axi_wlast_o = axi_wvalid_o && last_beat;

`ifdef IOB_AXIS2AXI_WR_BRESP_CHECK_EN
  logic error_q;

  // Sticky response error, cleared when the next command is accepted.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      error_q <= 1'b0;
    end else if (cke_i) begin
      if (cfg_fire) begin
        error_q <= 1'b0;
      end else if (axi_bvalid_i && axi_bready_o &&
                   ((axi_bresp_i != 2'b00) || (axi_bid_i != '0))) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error_o = error_q;
`else
  // Response status is not inspected in this build.
  logic unused_bresp;
  assign unused_bresp = ^{axi_bid_i, axi_bresp_i};
`endif

endmodule

// File: tb/tb_iob_axis2axi_wr.sv
// Directed testbench for iob_axis2axi_wr: drives commands and stream words,
// plays an AXI slave, logs AW/W traffic and compares it to hand-computed
// burst lists.
module tb_iob_axis2axi_wr;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] config_in_addr_i = '0;
  logic [31:0] config_in_length_i = '0;
  logic        config_in_valid_i = 1'b0;
  logic        config_in_ready_o;
  logic [31:0] axis_in_data_i = '0;
  logic        axis_in_valid_i = 1'b0;
  logic        axis_in_ready_o;
  logic [0:0]  axi_awid_o;
  logic [31:0] axi_awaddr_o;
  logic [7:0]  axi_awlen_o;
  logic [2:0]  axi_awsize_o;
  logic [1:0]  axi_awburst_o;
  logic [1:0]  axi_awlock_o;
  logic [3:0]  axi_awcache_o;
  logic [2:0]  axi_awprot_o;
  logic [3:0]  axi_awqos_o;
  logic        axi_awvalid_o;
  logic        axi_awready_i = 1'b0;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wstrb_o;
  logic        axi_wlast_o;
  logic        axi_wvalid_o;
  logic        axi_wready_i = 1'b0;
  logic [0:0]  axi_bid_i = '0;
  logic [1:0]  axi_bresp_i = 2'b00;
  logic        axi_bvalid_i = 1'b0;
  logic        axi_bready_o;
`ifdef IOB_AXIS2AXI_WR_BRESP_CHECK_EN
  logic        error_o;
`endif

  int checks = 0;
  int failures = 0;

  // Slave behaviour controls and traffic logs.
  logic        aw_hold = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        stop_stream = 1'b0;
  int          resp_owed = 0;
  logic        b_fire = 1'b0;
  int          acc_cnt = 0;
  logic        aw_seen = 1'b0;
  logic [31:0] aw_addr_q [$];
  logic [7:0]  aw_len_q [$];
  logic [31:0] w_data_q [$];
  logic        w_last_q [$];

  iob_axis2axi_wr dut (
    .clk_i              (clk),
    .cke_i              (1'b1),
    .arst_i             (arst),
    .config_in_addr_i   (config_in_addr_i),
    .config_in_length_i (config_in_length_i),
    .config_in_valid_i  (config_in_valid_i),
    .config_in_ready_o  (config_in_ready_o),
    .axis_in_data_i     (axis_in_data_i),
    .axis_in_valid_i    (axis_in_valid_i),
    .axis_in_ready_o    (axis_in_ready_o),
`ifdef IOB_AXIS2AXI_WR_BRESP_CHECK_EN
    .error_o            (error_o),
`endif
    .axi_awid_o         (axi_awid_o),
    .axi_awaddr_o       (axi_awaddr_o),
    .axi_awlen_o        (axi_awlen_o),
    .axi_awsize_o       (axi_awsize_o),
    .axi_awburst_o      (axi_awburst_o),
    .axi_awlock_o       (axi_awlock_o),
    .axi_awcache_o      (axi_awcache_o),
    .axi_awprot_o       (axi_awprot_o),
    .axi_awqos_o        (axi_awqos_o),
    .axi_awvalid_o      (axi_awvalid_o),
    .axi_awready_i      (axi_awready_i),
    .axi_wdata_o        (axi_wdata_o),
    .axi_wstrb_o        (axi_wstrb_o),
    .axi_wlast_o        (axi_wlast_o),
    .axi_wvalid_o       (axi_wvalid_o),
    .axi_wready_i       (axi_wready_i),
    .axi_bid_i          (axi_bid_i),
    .axi_bresp_i        (axi_bresp_i),
    .axi_bvalid_i       (axi_bvalid_i),
    .axi_bready_o       (axi_bready_o)
  );

  always #5 clk = ~clk;

  // Handshakes seen at the falling edge complete on the following rising edge.
  always @(negedge clk) begin
    if (!arst) begin
      if (axi_awvalid_o) aw_seen = 1'b1;
      if (axi_awvalid_o && axi_awready_i) begin
        aw_addr_q.push_back(axi_awaddr_o);
        aw_len_q.push_back(axi_awlen_o);
      end
      if (axi_wvalid_o && axi_wready_i) begin
        w_data_q.push_back(axi_wdata_o);
        w_last_q.push_back(axi_wlast_o);
        if (axi_wlast_o) resp_owed++;
      end
      if (axi_bvalid_i && axi_bready_o) b_fire = 1'b1;
      if (axis_in_valid_i && axis_in_ready_o) acc_cnt++;
    end
  end

  // AXI slave: ready generation and one write response per completed burst.
  always @(posedge clk) begin
    #1;
    if (arst) begin
      axi_bvalid_i = 1'b0;
      resp_owed    = 0;
      b_fire       = 1'b0;
    end else begin
      axi_awready_i = aw_hold ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      axi_wready_i  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (b_fire) begin
        axi_bvalid_i = 1'b0;
        b_fire       = 1'b0;
        resp_owed--;
      end
      if (!axi_bvalid_i && resp_owed > 0) axi_bvalid_i = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    aw_addr_q.delete();
    aw_len_q.delete();
    w_data_q.delete();
    w_last_q.delete();
    acc_cnt = 0;
    aw_seen = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [31:0] len);
    @(posedge clk); #1;
    config_in_addr_i   = addr;
    config_in_length_i = len;
    config_in_valid_i  = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    config_in_valid_i  = 1'b0;
  endtask

  task automatic drive_stream(input int n, input int base, input bit rnd);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 4000 && !stop_stream) begin
      @(posedge clk); #1;
      axis_in_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      axis_in_data_i  = 32'(base + sent);
      @(negedge clk);
      if (axis_in_valid_i && axis_in_ready_o) sent++;
      guard++;
    end
    @(posedge clk); #1;
    axis_in_valid_i = 1'b0;
    if (!stop_stream) begin
      checks++;
      if (sent != n) begin
        failures++;
        $display("FAIL stream_accept sent=%0d expected=%0d", sent, n);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!config_in_ready_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (config_in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_idle_timeout config_in_ready_o=%0b expected=1", name, config_in_ready_o);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    #12;
    checks++;
    if ({config_in_ready_o, axis_in_ready_o, axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_handshakes got=%b expected=100000",
               {config_in_ready_o, axis_in_ready_o, axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o});
    end
    checks++;
    if (axi_awaddr_o !== 32'h0 || axi_awlen_o !== 8'h0 || axi_wdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_payload awaddr=%0h awlen=%0h wdata=%0h expected=0/0/0",
               axi_awaddr_o, axi_awlen_o, axi_wdata_o);
    end
    checks++;
    if ({axi_awid_o, axi_awsize_o, axi_awburst_o, axi_awlock_o, axi_awcache_o, axi_awprot_o, axi_awqos_o, axi_wstrb_o}
        !== {1'b0, 3'd2, 2'd1, 2'd0, 4'd2, 3'd2, 4'd0, 4'hF}) begin
      failures++;
      $display("FAIL reset_aw_constants size=%0d burst=%0d cache=%0d prot=%0d wstrb=%0h expected=2/1/2/2/f",
               axi_awsize_o, axi_awburst_o, axi_awcache_o, axi_awprot_o, axi_wstrb_o);
    end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_len0();
    logic cfg_low = 1'b0;
    logic ax_rdy = 1'b0;
    clear_logs();
    axis_in_valid_i = 1'b1;
    send_cmd(32'h100, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!config_in_ready_o) cfg_low = 1'b1;
      if (axis_in_ready_o) ax_rdy = 1'b1;
    end
    axis_in_valid_i = 1'b0;
    checks++;
    if (cfg_low !== 1'b0) begin
      failures++;
      $display("FAIL len0_cfg_ready dropped=%0b expected=0", cfg_low);
    end
    checks++;
    if (aw_seen !== 1'b0) begin
      failures++;
      $display("FAIL len0_awvalid seen=%0b expected=0", aw_seen);
    end
    checks++;
    if (ax_rdy !== 1'b0 || acc_cnt != 0) begin
      failures++;
      $display("FAIL len0_axis_ready seen=%0b accepted=%0d expected=0/0", ax_rdy, acc_cnt);
    end
  endtask

  task automatic test_single_burst();
    int errs = 0;
    logic ax_rdy = 1'b0;
    clear_logs();
    send_cmd(32'h2000, 32'd16);
    drive_stream(16, 0, 1'b0);
    wait_idle("single");
    checks++;
    if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h2000 || aw_len_q[0] !== 8'd15) begin
      failures++;
      $display("FAIL single_aw count=%0d addr=%0h len=%0d expected=1/2000/15",
               aw_addr_q.size(), aw_addr_q.size() > 0 ? aw_addr_q[0] : 32'hx,
               aw_len_q.size() > 0 ? aw_len_q[0] : 8'hx);
    end
    checks++;
    if (w_data_q.size() != 16) begin
      failures++;
      $display("FAIL single_w_count got=%0d expected=16", w_data_q.size());
    end
    for (int i = 0; i < w_data_q.size(); i++)
      if (w_data_q[i] !== 32'(i) || w_last_q[i] !== (i == 15)) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL single_w_data_last bad_beats=%0d expected=0", errs);
    end
    // Extra stream words after the command is satisfied must not be taken.
    axis_in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (axis_in_ready_o) ax_rdy = 1'b1;
    end
    axis_in_valid_i = 1'b0;
    checks++;
    if (ax_rdy !== 1'b0 || acc_cnt != 16) begin
      failures++;
      $display("FAIL single_overrun ready_seen=%0b accepted=%0d expected=0/16", ax_rdy, acc_cnt);
    end
  endtask

  task automatic test_multi_burst();
    int errs = 0;
    clear_logs();
    send_cmd(32'h0, 32'd37);
    drive_stream(37, 100, 1'b0);
    wait_idle("multi");
    checks++;
    if (aw_addr_q.size() != 3) begin
      failures++;
      $display("FAIL multi_aw_count got=%0d expected=3", aw_addr_q.size());
    end else begin
      checks++;
      if (aw_addr_q[0] !== 32'h0 || aw_addr_q[1] !== 32'h40 || aw_addr_q[2] !== 32'h80 ||
          aw_len_q[0] !== 8'd15 || aw_len_q[1] !== 8'd15 || aw_len_q[2] !== 8'd4) begin
        failures++;
        $display("FAIL multi_aw got=%0h/%0d %0h/%0d %0h/%0d expected=0/15 40/15 80/4",
                 aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1], aw_addr_q[2], aw_len_q[2]);
      end
    end
    checks++;
    if (w_data_q.size() != 37) begin
      failures++;
      $display("FAIL multi_w_count got=%0d expected=37", w_data_q.size());
    end
    for (int i = 0; i < w_data_q.size(); i++)
      if (w_data_q[i] !== 32'(100 + i) || w_last_q[i] !== (i == 15 || i == 31 || i == 36)) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL multi_w_data_last bad_beats=%0d expected=0", errs);
    end
  endtask

  task automatic test_4k_boundary();
    int errs = 0;
    clear_logs();
    send_cmd(32'hFF8, 32'd8);
    drive_stream(8, 200, 1'b0);
    wait_idle("b4k");
    checks++;
    if (aw_addr_q.size() != 2) begin
      failures++;
      $display("FAIL b4k_aw_count got=%0d expected=2", aw_addr_q.size());
    end else begin
      checks++;
      if (aw_addr_q[0] !== 32'hFF8 || aw_len_q[0] !== 8'd1 ||
          aw_addr_q[1] !== 32'h1000 || aw_len_q[1] !== 8'd5) begin
        failures++;
        $display("FAIL b4k_aw got=%0h/%0d %0h/%0d expected=ff8/1 1000/5",
                 aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
      end
    end
    checks++;
    if (w_data_q.size() != 8) begin
      failures++;
      $display("FAIL b4k_w_count got=%0d expected=8", w_data_q.size());
    end
    for (int i = 0; i < w_data_q.size(); i++)
      if (w_data_q[i] !== 32'(200 + i) || w_last_q[i] !== (i == 1 || i == 7)) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL b4k_w_data_last bad_beats=%0d expected=0", errs);
    end
  endtask

  task automatic test_random_backpressure();
    int errs = 0;
    clear_logs();
    aw_hold = 1'b1;
    send_cmd(32'h3000, 32'd50);
    fork
      drive_stream(50, 300, 1'b1);
      begin
        repeat (200) @(negedge clk);
        checks++;
        if (acc_cnt != 32 || axis_in_ready_o !== 1'b0) begin
          failures++;
          $display("FAIL rand_fifo_full accepted=%0d ready=%0b expected=32/0", acc_cnt, axis_in_ready_o);
        end
        aw_hold   = 1'b0;
        rnd_ready = 1'b1;
      end
    join
    wait_idle("rand");
    rnd_ready = 1'b0;
    checks++;
    if (acc_cnt != 50) begin
      failures++;
      $display("FAIL rand_accept_count got=%0d expected=50", acc_cnt);
    end
    checks++;
    if (aw_addr_q.size() != 4) begin
      failures++;
      $display("FAIL rand_aw_count got=%0d expected=4", aw_addr_q.size());
    end else begin
      checks++;
      if (aw_addr_q[0] !== 32'h3000 || aw_addr_q[1] !== 32'h3040 || aw_addr_q[2] !== 32'h3080 ||
          aw_addr_q[3] !== 32'h30C0 || aw_len_q[0] !== 8'd15 || aw_len_q[1] !== 8'd15 ||
          aw_len_q[2] !== 8'd15 || aw_len_q[3] !== 8'd1) begin
        failures++;
        $display("FAIL rand_aw last_addr=%0h last_len=%0d expected=30c0/1", aw_addr_q[3], aw_len_q[3]);
      end
    end
    checks++;
    if (w_data_q.size() != 50) begin
      failures++;
      $display("FAIL rand_w_count got=%0d expected=50", w_data_q.size());
    end
    for (int i = 0; i < w_data_q.size(); i++)
      if (w_data_q[i] !== 32'(300 + i) || w_last_q[i] !== (i == 15 || i == 31 || i == 47 || i == 49)) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL rand_w_data_last bad_beats=%0d expected=0", errs);
    end
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    int errs = 0;
    clear_logs();
    send_cmd(32'h0, 32'd37);
    fork
      drive_stream(37, 400, 1'b0);
      begin
        while (aw_addr_q.size() < 2 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (aw_addr_q.size() < 2) begin
          failures++;
          $display("FAIL rstmid_second_aw got=%0d expected=2", aw_addr_q.size());
        end
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if ({config_in_ready_o, axis_in_ready_o, axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o} !== 6'b100000 ||
            axi_awaddr_o !== 32'h0 || axi_awlen_o !== 8'h0 || axi_wdata_o !== 32'h0) begin
          failures++;
          $display("FAIL rstmid_outputs hs=%b awaddr=%0h awlen=%0h wdata=%0h expected=100000/0/0/0",
                   {config_in_ready_o, axis_in_ready_o, axi_awvalid_o, axi_wvalid_o, axi_wlast_o, axi_bready_o},
                   axi_awaddr_o, axi_awlen_o, axi_wdata_o);
        end
        stop_stream = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    arst = 1'b0;
    stop_stream = 1'b0;
    clear_logs();
    send_cmd(32'h503, 32'd4);
    drive_stream(4, 500, 1'b0);
    wait_idle("rstmid_new");
    checks++;
    if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h500 || aw_len_q[0] !== 8'd3) begin
      failures++;
      $display("FAIL rstmid_new_aw count=%0d addr=%0h expected=1/500", aw_addr_q.size(),
               aw_addr_q.size() > 0 ? aw_addr_q[0] : 32'hx);
    end
    checks++;
    if (w_data_q.size() != 4) begin
      failures++;
      $display("FAIL rstmid_new_w_count got=%0d expected=4", w_data_q.size());
    end
    for (int i = 0; i < w_data_q.size(); i++)
      if (w_data_q[i] !== 32'(500 + i) || w_last_q[i] !== (i == 3)) errs++;
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL rstmid_new_w_data_last bad_beats=%0d expected=0", errs);
    end
  endtask

`ifdef IOB_AXIS2AXI_WR_BRESP_CHECK_EN
  task automatic test_bresp_error();
    clear_logs();
    axi_bresp_i = 2'd2;
    send_cmd(32'h600, 32'd4);
    drive_stream(4, 600, 1'b0);
    wait_idle("bresp");
    axi_bresp_i = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (error_o !== 1'b1) begin
      failures++;
      $display("FAIL bresp_error_set got=%0b expected=1", error_o);
    end
    send_cmd(32'h700, 32'd0);
    @(negedge clk);
    checks++;
    if (error_o !== 1'b0) begin
      failures++;
      $display("FAIL bresp_error_clear got=%0b expected=0", error_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_len0();
    test_single_burst();
    test_multi_burst();
    test_4k_boundary();
    test_random_backpressure();
    test_reset_mid_burst();
`ifdef IOB_AXIS2AXI_WR_BRESP_CHECK_EN
    test_bresp_error();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
